// File: rtl/enigma_c_if.sv
// Bus bundle between the enigma buffer port C, the scheduler and the downstream service.
interface enigma_c_if;
    // Buffer port C
    logic         valid_c;
    logic         ready_c;
    logic [127:0] payload_c;
    logic [5:0]   id_c;
    logic [1:0]   qos_c;
    logic         conflict_c;
    logic         release_c;
    logic [5:0]   releaseid_c;
    // Downstream request/completion
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_payload;
    logic [5:0]   req_id;
    logic [1:0]   req_qos;
    logic         cpl_valid;
    logic [5:0]   cpl_id;
    // Status
    logic         cpl_err;
    logic [6:0]   out_cnt;

    // Scheduler side
    modport slave (
        input  valid_c, payload_c, id_c, qos_c, req_ready, cpl_valid, cpl_id,
        output ready_c, conflict_c, release_c, releaseid_c,
               req_valid, req_payload, req_id, req_qos, cpl_err, out_cnt
    );

    // Buffer/downstream side
    modport master (
        output valid_c, payload_c, id_c, qos_c, req_ready, cpl_valid, cpl_id,
        input  ready_c, conflict_c, release_c, releaseid_c,
               req_valid, req_payload, req_id, req_qos, cpl_err, out_cnt
    );
endinterface

// File: rtl/enigma_c_scheduler.sv
// Port C sink: id tracking, two-level QoS queues with starvation bound, completion-to-release.
module enigma_c_scheduler #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUT    = 16,
    parameter int unsigned HI_QOS     = 2,
    parameter int unsigned STARVE_LIM = 3
) (
    input logic       clk,
    input logic       rst,
    enigma_c_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam int unsigned CW = 7;

    typedef struct packed {
        logic [127:0] payload;
        logic [5:0]   id;
        logic [1:0]   qos;
    } entry_t;

    entry_t        hi_mem_q [DEPTH];
    entry_t        lo_mem_q [DEPTH];
    logic [PW-1:0] hi_wr_q, hi_wr_d, hi_rd_q, hi_rd_d;
    logic [PW-1:0] lo_wr_q, lo_wr_d, lo_rd_q, lo_rd_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          sel_lo_q, sel_lo_d;
    logic          pend_q, pend_d;
    logic [63:0]   busy_q, busy_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          cpl_v_q, cpl_v_d;
    logic [5:0]    cpl_id_q, cpl_id_d;
    logic          release_q, release_d;
    logic [5:0]    relid_q, relid_d;
    logic          cpl_err_q, cpl_err_d;

    logic   hi_empty, lo_empty, hi_full, lo_full;
    logic   tgt_hi, tgt_full, busy_id, accept;
    logic   hi_push, lo_push, sel_lo_c, pop_hi, pop_lo, rel_hit;
    entry_t entry_in, head;

    // Queue status, admission and issue selection
    always_comb begin
        hi_empty = (hi_wr_q == hi_rd_q);
        lo_empty = (lo_wr_q == lo_rd_q);
        hi_full  = (hi_wr_q[AW] != hi_rd_q[AW]) && (hi_wr_q[AW-1:0] == hi_rd_q[AW-1:0]);
        lo_full  = (lo_wr_q[AW] != lo_rd_q[AW]) && (lo_wr_q[AW-1:0] == lo_rd_q[AW-1:0]);

        tgt_hi   = (32'(bus.qos_c) >= HI_QOS);
        tgt_full = tgt_hi ? hi_full : lo_full;
        busy_id  = busy_q[bus.id_c];

        bus.conflict_c = ~rst & bus.valid_c & busy_id;
        bus.ready_c    = ~rst & bus.valid_c & ~busy_id & ~tgt_full
                         & (out_cnt_q < CW'(MAX_OUT));
        accept         = bus.valid_c & bus.ready_c;
        hi_push        = accept & tgt_hi;
        lo_push        = accept & ~tgt_hi;

        entry_in.payload = bus.payload_c;
        entry_in.id      = bus.id_c;
        entry_in.qos     = bus.qos_c;

        // A request left pending keeps its queue so req_* stay stable
        sel_lo_c = pend_q ? sel_lo_q
                          : (~lo_empty & (hi_empty | (starve_q == SW'(STARVE_LIM))));
        head     = sel_lo_c ? lo_mem_q[lo_rd_q[AW-1:0]] : hi_mem_q[hi_rd_q[AW-1:0]];

        bus.req_valid   = ~rst & (~hi_empty | ~lo_empty);
        bus.req_payload = head.payload;
        bus.req_id      = head.id;
        bus.req_qos     = head.qos;

        pop_hi  = bus.req_valid & bus.req_ready & ~sel_lo_c;
        pop_lo  = bus.req_valid & bus.req_ready & sel_lo_c;

        rel_hit = cpl_v_q & busy_q[cpl_id_q];

        bus.release_c   = release_q;
        bus.releaseid_c = relid_q;
        bus.cpl_err     = cpl_err_q;
        bus.out_cnt     = out_cnt_q;
    end

    // Next-state for pointers, starvation counter, id tracking and completions
    always_comb begin
        hi_wr_d   = hi_wr_q;
        hi_rd_d   = hi_rd_q;
        lo_wr_d   = lo_wr_q;
        lo_rd_d   = lo_rd_q;
        starve_d  = starve_q;
        sel_lo_d  = sel_lo_c;
        pend_d    = bus.req_valid & ~bus.req_ready;
        busy_d    = busy_q;
        out_cnt_d = out_cnt_q;
        cpl_v_d   = bus.cpl_valid;
        cpl_id_d  = bus.cpl_id;
        release_d = rel_hit;
        relid_d   = rel_hit ? cpl_id_q : relid_q;
        cpl_err_d = cpl_err_q | (cpl_v_q & ~busy_q[cpl_id_q]);

        if (hi_push) hi_wr_d = hi_wr_q + PW'(1);
        if (lo_push) lo_wr_d = lo_wr_q + PW'(1);
        if (pop_hi)  hi_rd_d = hi_rd_q + PW'(1);
        if (pop_lo)  lo_rd_d = lo_rd_q + PW'(1);

        if (lo_empty || pop_lo) begin
            starve_d = '0;
        end else if (pop_hi && (starve_q != SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
        end

        if (accept)  busy_d[bus.id_c] = 1'b1;
        if (rel_hit) busy_d[cpl_id_q] = 1'b0;

        unique case ({accept, rel_hit})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Queue storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (hi_push) hi_mem_q[hi_wr_q[AW-1:0]] <= entry_in;
        if (lo_push) lo_mem_q[lo_wr_q[AW-1:0]] <= entry_in;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_wr_q   <= '0;
            hi_rd_q   <= '0;
            lo_wr_q   <= '0;
            lo_rd_q   <= '0;
            starve_q  <= '0;
            sel_lo_q  <= 1'b0;
            pend_q    <= 1'b0;
            busy_q    <= '0;
            out_cnt_q <= '0;
            cpl_v_q   <= 1'b0;
            cpl_id_q  <= '0;
            release_q <= 1'b0;
            relid_q   <= '0;
            cpl_err_q <= 1'b0;
        end else begin
            hi_wr_q   <= hi_wr_d;
            hi_rd_q   <= hi_rd_d;
            lo_wr_q   <= lo_wr_d;
            lo_rd_q   <= lo_rd_d;
            starve_q  <= starve_d;
            sel_lo_q  <= sel_lo_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            out_cnt_q <= out_cnt_d;
            cpl_v_q   <= cpl_v_d;
            cpl_id_q  <= cpl_id_d;
            release_q <= release_d;
            relid_q   <= relid_d;
            cpl_err_q <= cpl_err_d;
        end
    end
endmodule
